// File: rtl/sampstream_arb_if.sv
// Shared stream bundle: per-source sampleq ports plus the single
// downstream data/count/avail/pull stream.
interface sampstream_arb_if #(
  parameter int NUM_SRC = 4
);
  logic [8*NUM_SRC-1:0]  src_data;
  logic [10*NUM_SRC-1:0] src_count;
  logic [NUM_SRC-1:0]    src_avail;
  logic [NUM_SRC-1:0]    src_pull;
  logic [NUM_SRC-1:0]    src_enable;
  logic [7:0]            out_data;
  logic [9:0]            out_count;
  logic                  out_avail;
  logic                  out_pull;

  modport master (
    input  src_data, src_count, src_avail, src_enable, out_pull,
    output src_pull, out_data, out_count, out_avail
  );

  modport slave (
    output src_data, src_count, src_avail, src_enable, out_pull,
    input  src_pull, out_data, out_count, out_avail
  );
endinterface

// File: rtl/sampstream_arb.sv
// Round-robin arbiter sharing one byte stream between sampleq
// sources; each burst is a 2-byte header followed by whole words.
module sampstream_arb #(
  parameter int NUM_SRC   = 4,
  parameter int MAX_WORDS = 255
) (
  input  logic             clk,
  input  logic             rst,
  sampstream_arb_if.master bus,
  output logic             busy,
  output logic [2:0]       cur_src
);
  typedef enum logic [1:0] {
    IDLE, HDR0, HDR1, PAY
  } state_t;

  state_t             state, state_nx;
  logic [2:0]         rr_ptr, rr_ptr_nx;
  logic [2:0]         cur_src_nx;
  logic [7:0]         words, words_nx;
  logic [9:0]         cnt, cnt_nx;
  logic [NUM_SRC-1:0] req;
  logic               gnt_vld;
  logic [2:0]         gnt_idx;
  logic [9:0]         gnt_cnt;
  logic [9:0]         gnt_w10;
  logic [7:0]         gnt_words;
  logic [7:0]         cur_data;
  int                 scan_j;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i] = bus.src_avail[i] && bus.src_enable[i] &&
               (bus.src_count[10*i +: 10] != 10'd0);
    end
  end

  // Descending offset so the requester nearest rr_ptr wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan_j  = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      scan_j = int'(rr_ptr) + k;
      if (scan_j >= NUM_SRC) scan_j = scan_j - NUM_SRC;
      if (req[scan_j]) begin
        gnt_vld = 1'b1;
        gnt_idx = 3'(scan_j);
      end
    end
  end

  always_comb begin
    gnt_cnt  = '0;
    cur_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_idx == 3'(i)) gnt_cnt = bus.src_count[10*i +: 10];
      if (cur_src == 3'(i)) cur_data = bus.src_data[8*i +: 8];
    end
  end

  assign gnt_w10   = gnt_cnt >> 2;
  assign gnt_words = (gnt_w10 > 10'(MAX_WORDS)) ?
                     8'(MAX_WORDS) : gnt_w10[7:0];

  always_comb begin
    state_nx      = state;
    rr_ptr_nx     = rr_ptr;
    cur_src_nx    = cur_src;
    words_nx      = words;
    cnt_nx        = cnt;
    bus.out_avail = 1'b0;
    bus.out_data  = '0;
    bus.src_pull  = '0;
    unique case (state)
      IDLE: begin
        if (gnt_vld) begin
          state_nx   = HDR0;
          cur_src_nx = gnt_idx;
          words_nx   = gnt_words;
          cnt_nx     = 10'd2 + {gnt_words, 2'b00};
          rr_ptr_nx  = (gnt_idx == 3'(NUM_SRC - 1)) ?
                       3'd0 : gnt_idx + 3'd1;
        end
      end
      HDR0: begin
        bus.out_avail = 1'b1;
        bus.out_data  = 8'h80 | {5'd0, cur_src};
        if (bus.out_pull) begin
          state_nx = HDR1;
          cnt_nx   = cnt - 10'd1;
        end
      end
      HDR1: begin
        bus.out_avail = 1'b1;
        bus.out_data  = words;
        if (bus.out_pull) begin
          state_nx = (cnt == 10'd1) ? IDLE : PAY;
          cnt_nx   = cnt - 10'd1;
        end
      end
      PAY: begin
        bus.out_avail = 1'b1;
        bus.out_data  = cur_data;
        for (int i = 0; i < NUM_SRC; i++) begin
          bus.src_pull[i] = bus.out_pull && !rst &&
                            (cur_src == 3'(i));
        end
        if (bus.out_pull) begin
          cnt_nx = cnt - 10'd1;
          if (cnt == 10'd1) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      cur_src <= '0;
      words   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      rr_ptr  <= rr_ptr_nx;
      cur_src <= cur_src_nx;
      words   <= words_nx;
      cnt     <= cnt_nx;
    end
  end

  assign bus.out_count = cnt;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_sampstream_arb.sv
// Scoreboard bench for sampstream_arb: queue-level source and
// burst model feeding an expected-byte queue checked by a monitor.
module tb_sampstream_arb;
  localparam int N    = 4;
  localparam int MAXW = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [2:0] cur_src;

  sampstream_arb_if #(.NUM_SRC(N)) bus ();

  sampstream_arb #(
    .NUM_SRC  (N),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .cur_src(cur_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cnt;
    int         src;
    bit         last;
    bit         hdr;
    bit         bb;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  logic [7:0]  srcq[N][$];
  logic [N-1:0] en       = '0;
  logic [N-1:0] force_av = '0;
  logic [N-1:0] pend_pull = '0;
  int pull_mode = 0;
  int ph        = 0;
  int cap       = 1020;
  int checks    = 0;
  int fails     = 0;
  int cyc       = 0;
  int last_cyc  = 0;
  int pay_seen  = 0;
  int pull_seen = 0;
  int m_ptr     = 0;
  bit gap_chk   = 0;
  bit idle_nx   = 0;

  assign bus.src_enable = en;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic int vis_cnt(input int sz);
    int c;
    c = sz;
    if (c > 1020) c = 1020;
    if (c > cap) c = cap;
    return c & ~3;
  endfunction

  // Source side: sampleq-like FIFOs, popped on the pulls seen last negedge
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (pend_pull[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    end
    for (int i = 0; i < N; i++) begin
      bus.src_count[10*i +: 10] = 10'(vis_cnt(srcq[i].size()));
      bus.src_avail[i] = (srcq[i].size() > 0) || force_av[i];
      bus.src_data[8*i +: 8] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
    end
    case (pull_mode)
      0: bus.out_pull = 1'b1;
      1: bus.out_pull = 1'($urandom_range(0, 1));
      default: begin
        bus.out_pull = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end
    endcase
  end

  always @(negedge clk) begin
    cyc++;
    pend_pull = bus.src_pull;
    if (rst) begin
      idle_nx = 0;
      chk(bus.src_pull == '0, "rst_pull", int'(bus.src_pull), 0);
    end else begin
      if (idle_nx) begin
        idle_nx = 0;
        chk(!busy && !bus.out_avail, "end_idle",
            int'({busy, bus.out_avail}), 0);
      end
      if (bus.out_avail && bus.out_pull) begin
        if (expq.size() == 0) begin
          chk(0, "unexpected_byte", int'(bus.out_data), 0);
        end else begin
          mon_e = expq.pop_front();
          chk(bus.out_data == mon_e.data, "out_data",
              int'(bus.out_data), int'(mon_e.data));
          chk(int'(bus.out_count) == mon_e.cnt, "out_count",
              int'(bus.out_count), mon_e.cnt);
          if (mon_e.src >= 0) begin
            chk(bus.src_pull == N'(1 << mon_e.src), "src_pull",
                int'(bus.src_pull), 1 << mon_e.src);
            chk(int'(cur_src) == mon_e.src, "cur_src",
                int'(cur_src), mon_e.src);
            pay_seen++;
          end else begin
            chk(bus.src_pull == '0, "hdr_pull", int'(bus.src_pull), 0);
          end
          if (mon_e.hdr && mon_e.bb && gap_chk)
            chk(cyc - last_cyc == 2, "idle_gap", cyc - last_cyc, 2);
          if (mon_e.last) begin
            last_cyc = cyc;
            idle_nx  = 1;
          end
        end
      end else begin
        chk(bus.src_pull == '0, "stall_pull", int'(bus.src_pull), 0);
      end
      if (|bus.src_pull) pull_seen++;
    end
  end

  // Reference: replay whole bursts in round-robin order over the queues
  task automatic build(output int npay);
    int off[N];
    int g, j, c, w, tot;
    bit first;
    exp_t e;
    first = 1;
    npay  = 0;
    for (int i = 0; i < N; i++) off[i] = 0;
    forever begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && en[j] && vis_cnt(srcq[j].size() - off[j]) > 0) g = j;
      end
      if (g < 0) break;
      c   = vis_cnt(srcq[g].size() - off[g]);
      w   = (c / 4 > MAXW) ? MAXW : c / 4;
      tot = 2 + 4 * w;
      e = '{8'h80 | 8'(g), tot, -1, 1'b0, 1'b1, !first};
      expq.push_back(e);
      e = '{8'(w), tot - 1, -1, 1'b0, 1'b0, 1'b0};
      expq.push_back(e);
      for (int b = 0; b < 4 * w; b++) begin
        e = '{srcq[g][off[g] + b], tot - 2 - b, g,
              (b == 4 * w - 1), 1'b0, 1'b0};
        expq.push_back(e);
      end
      off[g] += 4 * w;
      npay   += 4 * w;
      m_ptr   = (g + 1) % N;
      first   = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int s, input int nbytes);
    for (int b = 0; b < nbytes; b++) srcq[s].push_back(8'($urandom));
  endtask

  task automatic drain(input int npay, input string nm);
    int n, budget;
    n = 0;
    budget = expq.size() * 8 + 100;
    step();
    while ((expq.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    chk(expq.size() == 0 && !busy, {nm, "_drain"}, expq.size(), 0);
    step();
    step();
    chk(pull_seen == npay, {nm, "_pulls"}, pull_seen, npay);
  endtask

  initial begin
    int np, n;
    repeat (3) step();
    chk(!bus.out_avail && bus.out_count == 0 && bus.out_data == 0,
        "reset_out", int'({bus.out_avail, bus.out_count, bus.out_data}), 0);
    chk(!busy && cur_src == 0 && bus.src_pull == 0, "reset_ctl",
        int'({busy, cur_src, bus.src_pull}), 0);
    rst = 1'b0;
    en  = '1;
    step();

    // single source, 12 bytes
    gap_chk = 1; pull_seen = 0;
    load(1, 12);
    build(np);
    drain(np, "single");

    // round-robin with sources showing 4 bytes at a time
    cap = 4; pull_seen = 0;
    load(0, 8); load(2, 8); load(3, 8);
    build(np);
    drain(np, "rr");
    cap = 1020;

    // clamp to MAXW words per burst
    pull_seen = 0;
    load(0, 1020);
    build(np);
    drain(np, "clamp");

    // stalled downstream
    gap_chk = 0; pull_mode = 2; pull_seen = 0;
    load(3, 16); load(1, 8);
    build(np);
    drain(np, "stall");
    pull_mode = 0;

    // masked source and zero-count source
    en = 4'b1110; force_av = 4'b0010; pull_seen = 0; pay_seen = 0;
    load(0, 8); load(2, 32);
    build(np);
    n = 0;
    while (pay_seen < 3 && n < 200) begin step(); n++; end
    chk(pay_seen >= 3, "mask_start", pay_seen, 3);
    en[2] = 1'b0;
    drain(np, "mask");
    chk(srcq[0].size() == 8, "mask_src0", srcq[0].size(), 8);
    srcq[0].delete();
    force_av = '0;
    step(); step();
    en = '1;

    // randomized traffic
    pull_mode = 1;
    for (int it = 0; it < 4; it++) begin
      en = N'($urandom_range(1, (1 << N) - 1));
      pull_seen = 0;
      for (int s = 0; s < N; s++) load(s, 4 * $urandom_range(0, 20));
      build(np);
      drain(np, "rand");
      for (int s = 0; s < N; s++) if (!en[s]) srcq[s].delete();
      step(); step();
      en = '1;
    end
    pull_mode = 0;

    // reset during payload
    pay_seen = 0;
    load(2, 40); load(0, 8); load(1, 8);
    build(np);
    n = 0;
    while (pay_seen < 5 && n < 200) begin step(); n++; end
    chk(pay_seen >= 5 && busy, "rst_pay", pay_seen, 5);
    rst = 1'b1;
    for (int s = 0; s < N; s++) srcq[s].delete();
    expq.delete();
    step();
    chk(!bus.out_avail && !busy && bus.src_pull == 0,
        "rst_idle", int'({bus.out_avail, busy, bus.src_pull}), 0);
    chk(bus.out_count == 0 && cur_src == 0, "rst_regs",
        int'({bus.out_count, cur_src}), 0);
    rst = 1'b0;
    m_ptr = 0; pull_seen = 0; gap_chk = 1;
    load(0, 8); load(3, 8);
    build(np);
    drain(np, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/sampstream_arb.md
Name: sampstream_arb

Overview:
- Shares one host byte stream between NUM_SRC sampleq instances, so several capture channels reach the host over a single command/stream path.
- Grants one source at a time, round-robin, and emits a 2-byte burst header before forwarding that source's payload bytes.
- Sits between the sampleq stream ports (data/count/avail/pull) and the downstream packetizer, which uses the same four-signal stream protocol.

Parameters:
- NUM_SRC, 4: number of sampleq sources; legal range 2..8.
- MAX_WORDS, 255: maximum payload words (4 bytes each) per burst; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- src_data  in  8*NUM_SRC  per-source stream byte; source i on bits [8i+7:8i].
- src_count  in  10*NUM_SRC  per-source bytes available; always a multiple of 4, at most 1020.
- src_avail  in  NUM_SRC  per-source stream available.
- src_pull  out  NUM_SRC  per-source byte consumed; one-hot or zero.
- src_enable  in  NUM_SRC  arbitration mask; a source with a 0 bit is never granted.
- out_data  out  8  current output byte.
- out_count  out  10  bytes remaining in the current burst, header included.
- out_avail  out  1  output byte valid.
- out_pull  in  1  downstream consumes out_data this cycle.
- busy  out  1  a burst is in progress (state is not IDLE).
- cur_src  out  3  granted source index; valid while busy.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, cur_src=0, src_pull=0, out_avail=0, out_count=0, out_data=0, busy=0.
- Request condition: req[i] = src_avail[i] && src_enable[i] && src_count[i] != 0.
- IDLE, grant selection:
  - Choose the first i with req[i] set, scanning cyclically rr_ptr, rr_ptr+1, ..., NUM_SRC-1, 0, ..., rr_ptr-1.
  - On a grant, latch cur_src=i and words = min(src_count[i]/4, MAX_WORDS).
  - Set rr_ptr = i+1, wrapping to 0 at NUM_SRC.
  - Go to HDR0 on the next cycle. The grant decision costs 1 cycle.
  - No request: stay in IDLE, out_avail=0.
- HDR0:
  - out_avail=1, out_data = 8'h80 | cur_src, out_count = 2 + 4*words.
  - out_pull: go to HDR1 and decrement out_count.
- HDR1:
  - out_avail=1, out_data = words.
  - out_pull: go to PAY and decrement out_count.
- PAY:
  - out_data = src_data[cur_src], combinational pass-through; out_avail=1.
  - src_pull[cur_src] = out_pull, combinational, same cycle. No other src_pull bit is ever asserted.
  - Each pull decrements out_count.
  - When the pull consumes the last byte (out_count==1), go to IDLE. out_avail is 0 in the following cycle.
- Payload count trust: the count latched at grant is trusted for the whole burst. src_avail dropping during PAY does not stall or abort the burst. This is valid because sampleq guarantees its count bytes.
- Payload byte order: payload words are forwarded whole, in source byte order. The burst length is always a multiple of 4, so source byte position stays aligned.
- out_pull while out_avail=0 is ignored: no state change, no src_pull.
- src_enable changes:
  - Take effect only at the next IDLE grant decision.
  - Clearing the enable bit of cur_src mid-burst does not abort the burst.
- Widths: out_count maximum is 2+1020 = 1022, which fits in 10 bits. words is 8 bits.
- Back-to-back bursts:
  - After PAY ends, IDLE occupies exactly 1 cycle before the next HDR0 if any request is pending.
  - A source that is still requesting is re-granted only after every other requesting source has had a turn.
- rst asserted in any state:
  - Next cycle is IDLE with all outputs at their reset values.
  - No src_pull is asserted in the cycle rst is high.
  - Any partial burst is discarded. The sampleq instances are reset or restarted by firmware alongside this block.

Test Plan:
- Single source: src 1 requests with count=12 and out_pull is held high → out bytes 0x81, 0x03, then 12 source bytes. src_pull[1] is high for exactly 12 cycles. busy falls after the last byte. out_count runs 14 down to 1.
- Round-robin: src 0, 2 and 3 all request continuously with count=4 → grant order 0, 2, 3, 0, 2, 3. Headers read 0x80, 0x82, 0x83, with 1 idle cycle between bursts.
- Clamp: MAX_WORDS=16 and src 0 count=1020 → header byte 2 is 0x10, the burst is 64 payload bytes, and src_pull is asserted 64 times.
- Stall: out_pull toggles 1,0,0,1 during PAY → src_pull mirrors out_pull exactly. The byte sequence is unchanged and out_count decrements only on pull cycles.
- Mask and zero count: src 0 has enable=0 and count=8, src 1 has enable=1 and count=0, src 2 has enable=1 and count=4 → only src 2 is granted. src_enable[2] cleared mid-burst → the burst still completes.
- Reset mid-PAY: rst asserted after 5 payload bytes → next cycle state=IDLE, out_avail=0, src_pull=0, rr_ptr=0. After rst releases, src 0 is granted first.
